// File: rtl/cnn_layer_sequencer_if.sv
// Control handshake bundle between the system/engine side and the CNN layer sequencer.
// The sequencer takes the slave modport; the system-level controller takes the master modport.
interface cnn_layer_sequencer_if #(
  parameter int LAYER_W = 2
);
  logic               start;
  logic               abort;
  logic               err_clear;
  logic               conv_done;
  logic               pool_done;
  logic               conv_start;
  logic               pool_start;
  logic [LAYER_W-1:0] layer_idx;
  logic               busy;
  logic               done;
  logic               timeout;

  modport master (
    output start, abort, err_clear, conv_done, pool_done,
    input  conv_start, pool_start, layer_idx, busy, done, timeout
  );

  modport slave (
    input  start, abort, err_clear, conv_done, pool_done,
    output conv_start, pool_start, layer_idx, busy, done, timeout
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Steps the shared conv and pool engines through NUM_LAYERS layers with per-stage timeout.
// All outputs are registers or Moore decodes of the state register.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 2,
  parameter int LAYER_W        = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cnn_layer_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_ISSUE,
    S_CONV_WAIT,
    S_POOL_ISSUE,
    S_POOL_WAIT,
    S_FINISH,
    S_ERROR
  } state_e;

  localparam bit                 TO_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0]    TO_LAST    = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               timeout_q, timeout_d;
  logic               busy_w;
  logic               to_hit;

  assign busy_w = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign to_hit = TO_EN && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      layer_q   <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    // Abort beats every other event, including a coincident done or timeout expiry.
    if (busy_w && bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d   = S_CONV_ISSUE;
            layer_d   = '0;
            timeout_d = 1'b0;
          end
        end
        S_CONV_ISSUE: begin
          state_d  = S_CONV_WAIT;
          to_cnt_d = '0;
        end
        S_CONV_WAIT: begin
          if (bus.conv_done) begin
            state_d = S_POOL_ISSUE;
          end else if (to_hit) begin
            state_d   = S_ERROR;
            timeout_d = 1'b1;
          end else if (TO_EN) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_POOL_ISSUE: begin
          state_d  = S_POOL_WAIT;
          to_cnt_d = '0;
        end
        S_POOL_WAIT: begin
          if (bus.pool_done) begin
            if (layer_q == LAYER_LAST) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_CONV_ISSUE;
              layer_d = layer_q + LAYER_W'(1);
            end
          end else if (to_hit) begin
            state_d   = S_ERROR;
            timeout_d = 1'b1;
          end else if (TO_EN) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        S_ERROR: begin
          if (bus.err_clear) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.conv_start = (state_q == S_CONV_ISSUE);
  assign bus.pool_start = (state_q == S_POOL_ISSUE);
  assign bus.done       = (state_q == S_FINISH);
  assign bus.busy       = busy_w;
  assign bus.layer_idx  = layer_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Randomized bench for cnn_layer_sequencer: each run is planned as a timeline of stage
// start/done times, and every output is compared cycle by cycle against that timeline.
`timescale 1ns/1ps
module tb_cnn_layer_sequencer;
  localparam int NL = 2;
  localparam int LW = 2;
  localparam int TO = 8;
  localparam int TW = 4;
  localparam int NS = 2 * NL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cnn_layer_sequencer_if #(.LAYER_W(LW)) bus();

  cnn_layer_sequencer #(
    .NUM_LAYERS(NL), .LAYER_W(LW), .TIMEOUT_CYCLES(TO), .TO_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int run_id   = 0;
  int cyc_r    = 0;

  // Run plan: stage s (even = conv, odd = pool) is issued at cycle st[s] and its done
  // arrives d[s] cycles later; a done later than TO cycles means the stage times out.
  int d [NS];
  int st[NS];
  bit iss[NS];
  int nst, t_fin, t_err, t_last, ra;
  bit completed, errored, aborting;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s run %0d cycle %0d: got %0d, expected %0d", tag, run_id, cyc_r, obs, exp);
    end
  endtask

  task automatic plan_run(input int mode, input bit allow_abort);
    int t;
    int n;
    t = 1; nst = 0; completed = 0; errored = 0; aborting = 0;
    t_fin = -1; t_err = -1; ra = -1;
    for (int s = 0; s < NS; s++) begin
      int k;
      k = int'($urandom % 12);
      case (mode)
        1, 4:    d[s] = 5;
        2:       d[s] = (s == 0) ? 100 : 5;
        3:       d[s] = TO;
        default: d[s] = (k < 3) ? TO : (k == 3) ? TO + 1 + int'($urandom % 4) : int'($urandom_range(1, TO - 1));
      endcase
      iss[s] = (mode == 0) && ($urandom % 4 == 0);
    end
    for (int s = 0; s < NS && !errored; s++) begin
      st[s] = t;
      nst++;
      if (d[s] <= TO) t += d[s] + 1;
      else begin
        errored = 1;
        t_err   = t + TO + 1;
      end
    end
    if (errored) t_last = t_err - 1;
    else begin
      completed = 1;
      t_fin     = t;
      t_last    = t;
    end
    if (mode == 4 || (allow_abort && $urandom % 5 == 0)) begin
      aborting = 1;
      ra = (mode == 4) ? st[NS-1] + 2 : int'($urandom_range(1, completed ? t_last - 1 : t_last));
      completed = 0; errored = 0; t_last = ra;
      n = 0;
      for (int s = 0; s < nst; s++) if (st[s] <= ra) n++;
      nst = n;
    end
  endtask

  function automatic int stage_at(input int r);
    int s_at;
    int rr;
    s_at = 0;
    rr = (r > t_last) ? t_last : r;
    for (int s = 0; s < nst; s++) if (st[s] <= rr) s_at = s;
    return s_at;
  endfunction

  function automatic int exp_pulse(input int r, input int kind);
    for (int s = 0; s < nst; s++) if (st[s] == r && s % 2 == kind) return 1;
    return 0;
  endfunction

  task automatic run_one(input int mode, input bit allow_abort, input int rst_at);
    int rl;
    plan_run(mode, allow_abort);
    run_id++;
    rl = t_last + 5;
    // Start together with abort: abort is meaningless in IDLE, so the run must start.
    bus.start = 1'b1;
    bus.abort = (mode == 0) && ($urandom % 4 == 0);
    for (int r = 1; r <= rl; r++) begin
      @(negedge clk);
      cyc_r = r;
      check_val("conv_start", bus.conv_start, exp_pulse(r, 0));
      check_val("pool_start", bus.pool_start, exp_pulse(r, 1));
      check_val("done", bus.done, (completed && r == t_fin) ? 1 : 0);
      check_val("busy", bus.busy, (r <= t_last) ? 1 : 0);
      check_val("timeout", bus.timeout, (errored && r >= t_err) ? 1 : 0);
      check_val("layer_idx", bus.layer_idx, stage_at(r) / 2);
      bus.start = 0; bus.abort = 0; bus.conv_done = 0; bus.pool_done = 0; bus.err_clear = 0;
      if (r == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_conv_start", bus.conv_start, 0);
        check_val("rst_pool_start", bus.pool_start, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_timeout", bus.timeout, 0);
        check_val("rst_layer", bus.layer_idx, 0);
        return;
      end
      if (r < rl) begin
        for (int s = 0; s < nst; s++) begin
          if (r == st[s] + d[s] || (iss[s] && r == st[s])) begin
            if (s % 2 == 0) bus.conv_done = 1'b1;
            else            bus.pool_done = 1'b1;
          end
        end
        if (mode == 0 && r <= t_last) begin
          if ($urandom % 6 == 0) begin
            if (stage_at(r) % 2 == 0) bus.pool_done = 1'b1;
            else                      bus.conv_done = 1'b1;
          end
          if ($urandom % 8 == 0 && !(aborting && r >= ra)) bus.start = 1'b1;
        end
        if (aborting && r == ra) bus.abort = 1'b1;
      end
    end
    if (errored) begin
      bus.err_clear = 1'b1;
      @(negedge clk);
      cyc_r = rl + 1;
      bus.err_clear = 1'b0;
      check_val("clr_busy", bus.busy, 0);
      check_val("clr_timeout", bus.timeout, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog run %0d: simulation did not complete, got timeout, expected finish", run_id);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.abort = 0; bus.err_clear = 0; bus.conv_done = 0; bus.pool_done = 0;
    repeat (3) @(negedge clk);
    check_val("init_busy", bus.busy, 0);
    check_val("init_done", bus.done, 0);
    check_val("init_conv_start", bus.conv_start, 0);
    check_val("init_pool_start", bus.pool_start, 0);
    check_val("init_timeout", bus.timeout, 0);
    check_val("init_layer", bus.layer_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one(1, 0, 0);   // nominal, every done 5 cycles after its start
    run_one(2, 0, 0);   // conv_done never arrives
    run_one(1, 0, 0);   // a fresh start clears the sticky timeout
    run_one(3, 0, 0);   // every done lands on the last allowed wait cycle
    run_one(4, 0, 0);   // abort in layer 1 pool wait
    run_one(1, 0, 0);   // restart after abort begins at layer 0
    for (int i = 0; i < 40; i++) run_one(0, 1, 0);

    run_one(1, 0, 15);  // async reset in layer 1 conv wait
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_busy", bus.busy, 0);
    check_val("post_rst_layer", bus.layer_idx, 0);
    run_one(1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Sequences the CNN datapath through NUM_LAYERS layers, each a conv stage followed by a pool stage.
- Issues one-cycle start pulses to the shared conv and pool engines and waits for their done pulses.
- Exposes the current layer index for weight/buffer address selection.
- Guards each stage with a timeout, and reports run completion or error to the system level.

Parameters:
- NUM_LAYERS, 2, number of conv+pool layers per run; must be >= 1.
- LAYER_W, 2, width of layer_idx; must satisfy 2^LAYER_W >= NUM_LAYERS.
- TIMEOUT_CYCLES, 1000, max WAIT-state cycles per stage before error; 0 disables the timeout.
- TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a run; sampled only in IDLE
- abort  input  1  cancel the run in progress; highest priority
- err_clear  input  1  leave ERROR state
- conv_done  input  1  one-cycle pulse from the conv engine
- pool_done  input  1  one-cycle pulse from the pool engine
- conv_start  output  1  one-cycle pulse to the conv engine
- pool_start  output  1  one-cycle pulse to the pool engine
- layer_idx  output  LAYER_W  layer currently being processed
- busy  output  1  high in every state except IDLE and ERROR
- done  output  1  one-cycle pulse at run completion
- timeout  output  1  sticky error flag

Behaviour:
- All outputs are registered or pure Moore decodes of the state register. There are no combinational input-to-output paths.
- Reset: state=IDLE, layer_idx=0, timeout=0, conv_start=pool_start=done=busy=0, to_cnt=0.
- States: IDLE, CONV_ISSUE, CONV_WAIT, POOL_ISSUE, POOL_WAIT, FINISH, ERROR.
- IDLE: start=1 -> CONV_ISSUE, layer_idx<=0, timeout<=0.
- CONV_ISSUE: conv_start=1 for exactly this cycle. Always -> CONV_WAIT; to_cnt<=0.
- CONV_WAIT:
  - conv_done=1 -> POOL_ISSUE.
  - Otherwise, if TIMEOUT_CYCLES!=0 and to_cnt==TIMEOUT_CYCLES-1 -> ERROR, timeout<=1.
  - Otherwise to_cnt++.
- POOL_ISSUE: pool_start=1 for this cycle only. Always -> POOL_WAIT; to_cnt<=0.
- POOL_WAIT:
  - pool_done=1 with layer_idx==NUM_LAYERS-1 -> FINISH.
  - pool_done=1 otherwise -> CONV_ISSUE, layer_idx<=layer_idx+1.
  - Timeout handling is the same as CONV_WAIT.
- FINISH: done=1 for this cycle. Always -> IDLE. layer_idx holds its last value until the next start.
- ERROR: busy=0. err_clear=1 -> IDLE. timeout stays 1 until the next accepted start or reset.
- Latency:
  - start sampled at edge N -> conv_start high in cycle N+1.
  - done sampled at edge M -> next *_start high in cycle M+1.
  - Last pool_done -> done pulse one cycle later.
- Done pulses outside their own WAIT state are ignored, including a done coincident with the ISSUE cycle and a pool_done while in CONV_WAIT.
- A done pulse arriving in the same cycle as the timeout expiry wins: normal transition, no error.
- abort=1 in any state except IDLE/ERROR -> IDLE next edge. No done pulse, layer_idx unchanged, timeout unchanged. abort in IDLE/ERROR has no effect.
- start while busy is ignored. start and abort together in IDLE: abort has no effect in IDLE, so the run starts.
- Asynchronous reset mid-run returns immediately to the reset values. Engines must tolerate a dropped handshake.
- No arithmetic wrap: layer_idx never exceeds NUM_LAYERS-1, and to_cnt never exceeds TIMEOUT_CYCLES-1.

Test Plan:
- Nominal run, NUM_LAYERS=2, each done returned 5 cycles after its start. Required response:
  - Start pulses appear in order conv, pool, conv, pool.
  - layer_idx reads 0,0,1,1 at those pulses.
  - done pulses exactly once, 1 cycle after the second pool_done.
  - busy is high from cycle N+1 to the FINISH cycle inclusive.
- Timeout, TIMEOUT_CYCLES=8, conv_done never sent:
  - Enter ERROR 8 cycles after CONV_WAIT entry; timeout=1, busy=0.
  - err_clear -> IDLE with timeout still 1.
  - A new start clears timeout.
- Race at the limit: conv_done arrives on the final wait cycle (to_cnt=7, TIMEOUT_CYCLES=8) -> POOL_ISSUE, timeout stays 0.
- Abort mid-run: abort during layer 1 POOL_WAIT -> IDLE next cycle, no done pulse, layer_idx=1. A following start restarts at layer_idx=0.
- Spurious handshakes:
  - conv_done held during CONV_ISSUE and pool_done during CONV_WAIT are both ignored; the state remains CONV_WAIT.
  - start pulsed while busy does not restart the run or emit an extra conv_start.
- Async reset asserted in CONV_WAIT of layer 1 -> all outputs at reset values immediately, without waiting for a clock edge.
